// File: rtl/ula_nb_seq.sv
// N-bit registered ALU (AND/OR/ADD/SUB/SLT/NOR) with a shift-add unsigned multiplier
// and a valid/ready handshake on both sides.
module ula_nb_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [1:0]       op,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam int         CW      = $clog2(WIDTH + 1);

  logic [1:0]         state_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   result_r;
  logic               cout_r;
  logic               zero_r;
  logic               overflow_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt_r;

  logic               mul_s;
  logic               accept_s;
  logic [WIDTH-1:0]   a_mod_s;
  logic [WIDTH-1:0]   b_mod_s;
  logic [WIDTH:0]     sum_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_cout_s;
  logic               alu_ovf_s;
  logic [WIDTH:0]     hi_sum_s;
  logic [2*WIDTH-1:0] next_prod_s;
  logic               mul_last_s;

  assign mul_s    = MUL_EN & mul;
  assign in_ready = (state_r != ST_MUL) & (~out_valid_r | out_ready) & ~reset;
  assign accept_s = in_valid & in_ready;

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign cout      = cout_r;
  assign zero      = zero_r;
  assign overflow  = overflow_r;

  // Shared adder; binvert doubles as carry-in so binvert=1 gives A'-B.
  assign a_mod_s = ainvert ? ~a : a;
  assign b_mod_s = binvert ? ~b : b;
  assign sum_s   = {1'b0, a_mod_s} + {1'b0, b_mod_s} + {{WIDTH{1'b0}}, binvert};
  assign ovf_s   = (a_mod_s[WIDTH-1] == b_mod_s[WIDTH-1]) & (sum_s[WIDTH-1] != a_mod_s[WIDTH-1]);

  // ALU result and flag selection.
  always_comb begin
    alu_res_s  = {WIDTH{1'b0}};
    alu_cout_s = 1'b0;
    alu_ovf_s  = 1'b0;
    case (op)
      2'b00: alu_res_s = a_mod_s & b_mod_s;
      2'b01: alu_res_s = a_mod_s | b_mod_s;
      2'b10: begin
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
        alu_ovf_s  = ovf_s;
      end
      2'b11: begin
        alu_res_s  = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
        alu_cout_s = sum_s[WIDTH];
        alu_ovf_s  = ovf_s;
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Multiplier lives in prod_r low half and shifts out as the product shifts in.
  assign hi_sum_s    = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                       (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
  assign next_prod_s = {hi_sum_s, prod_r[WIDTH-1:1]};
  assign mul_last_s  = (cnt_r == CW'(WIDTH - 1));

  // Control FSM, operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
      mcand_r     <= {WIDTH{1'b0}};
      prod_r      <= {(2*WIDTH){1'b0}};
      cnt_r       <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_MUL: begin
          prod_r <= next_prod_s;
          if (mul_last_s) begin
            cnt_r       <= {CW{1'b0}};
            result_r    <= next_prod_s[WIDTH-1:0];
            cout_r      <= |next_prod_s[2*WIDTH-1:WIDTH];
            zero_r      <= (next_prod_s[WIDTH-1:0] == {WIDTH{1'b0}});
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_IDLE, ST_HOLD: begin
          if (accept_s) begin
            if (mul_s) begin
              mcand_r     <= a;
              prod_r      <= {{WIDTH{1'b0}}, b};
              cnt_r       <= {CW{1'b0}};
              out_valid_r <= 1'b0;
              state_r     <= ST_MUL;
            end else begin
              result_r    <= alu_res_s;
              cout_r      <= alu_cout_s;
              zero_r      <= (alu_res_s == {WIDTH{1'b0}});
              overflow_r  <= alu_ovf_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
            end
          end else if (out_valid_r & out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_nb_seq.sv
// Scoreboard bench for ula_nb_seq: directed spec cases, backpressure, reset abort,
// and randomized traffic checked against an arithmetic reference model.
module tb_ula_nb_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         o;
  } exp_t;

  typedef struct {
    exp_t e;
    int   due;
  } sb_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ainvert;
  logic         binvert;
  logic [1:0]   op;
  logic         mul;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         overflow;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  bit  rand_ready = 1'b0;
  sb_t sb[$];

  ula_nb_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ainvert(ainvert), .binvert(binvert), .op(op), .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the modified operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mai, input logic mbi,
                                 input logic [1:0] mop, input logic mm);
    exp_t         e;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [63:0]  p;
    longint       s;
    longint       us;
    logic         carry;
    logic         ovf;
    e = '0;
    if (mm) begin
      p     = {32'd0, ma} * {32'd0, mb};
      e.res = p[31:0];
      e.c   = (p[63:32] != 32'd0);
      e.o   = 1'b0;
    end else begin
      ea    = mai ? ~ma : ma;
      eb    = mbi ? ~mb : mb;
      s     = longint'($signed(ea)) + longint'($signed(eb)) + longint'(mbi);
      us    = longint'({32'd0, ea}) + longint'({32'd0, eb}) + longint'(mbi);
      carry = (us >= 64'sd4294967296);
      ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      case (mop)
        2'b00:   begin e.res = ea & eb; e.c = 1'b0; e.o = 1'b0; end
        2'b01:   begin e.res = ea | eb; e.c = 1'b0; e.o = 1'b0; end
        2'b10:   begin e.res = s[31:0]; e.c = carry; e.o = ovf; end
        default: begin e.res = (s < 0) ? 32'd1 : 32'd0; e.c = carry; e.o = ovf; end
      endcase
    end
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tai, input logic tbi, input logic [1:0] top,
                      input logic tm, input exp_t e);
    bit  ok;
    sb_t item;
    ok = 1'b0;
    a = ta; b = tb_v; ainvert = tai; binvert = tbi; op = top; mul = tm;
    in_valid = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      item.e   = e;
      item.due = cyc + (tm ? W : 0);
      sb.push_back(item);
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops and compares on every output transfer; checks latency and hold.
  initial begin
    bit          presented;
    bit          stall_prev;
    logic [35:0] held;
    presented  = 1'b0;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        presented  = 1'b0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("hold_stable", {28'd0, out_valid, result, cout, zero, overflow},
                {28'd0, 1'b1, held[34:0]});
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_output", {32'd0, result}, 64'd0 - 64'd1);
          end else begin
            if (!presented) begin
              check("latency", 64'(cyc), 64'(sb[0].due));
              check("data", {29'd0, result, cout, zero, overflow}, {29'd0, sb[0].e});
              presented = 1'b1;
            end
            if (out_ready) begin
              void'(sb.pop_front());
              presented = 1'b0;
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        held       = {1'b0, out_valid, result, cout, zero, overflow};
      end
    end
  end

  // Random consumer backpressure, enabled only in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rai;
    logic         rbi;
    logic [1:0]   rop;
    logic         rm;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ainvert = 1'b0; binvert = 1'b0; op = 2'b00; mul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", {58'd0, out_valid, in_ready, cout, zero, overflow, |result},
          64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed cases with hand-computed expectations.
    send(32'd5, 32'd3, 1'b0, 1'b0, 2'b10, 1'b0, '{32'd8, 1'b0, 1'b0, 1'b0});
    send(32'd3, 32'd5, 1'b0, 1'b1, 2'b10, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    send(32'd3, 32'd5, 1'b0, 1'b1, 2'b11, 1'b0, '{32'd1, 1'b0, 1'b0, 1'b0});
    send(32'd5, 32'd3, 1'b0, 1'b1, 2'b11, 1'b0, '{32'd0, 1'b1, 1'b1, 1'b0});
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 2'b10, 1'b0, '{32'h8000_0000, 1'b0, 1'b0, 1'b1});
    send(32'd0, 32'd0, 1'b1, 1'b1, 2'b00, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    send(32'h0F0F_0000, 32'h00F0_00FF, 1'b0, 1'b0, 2'b01, 1'b0,
         '{32'h0FFF_00FF, 1'b0, 1'b0, 1'b0});

    send(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 2'b00, 1'b1, '{32'd0, 1'b1, 1'b1, 1'b0});
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("in_ready_mul", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    send(32'd7, 32'd6, 1'b0, 1'b0, 2'b00, 1'b1, '{32'd42, 1'b0, 1'b0, 1'b0});
    repeat (W + 2) @(posedge clk);
    #1;

    // Backpressure mid-stream on 4 back-to-back ADDs.
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(32'd100 + 32'(i), 32'd10, 1'b0, 1'b0, 2'b10, 1'b0,
               '{32'd110 + 32'(i), 1'b0, 1'b0, 1'b0});
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset ten cycles into a multiply aborts it.
    send(32'd9, 32'd9, 1'b0, 1'b0, 2'b00, 1'b1, '{32'd81, 1'b0, 1'b0, 1'b0});
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_abort", {32'd0, out_valid, in_ready, result[29:0]}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    send(32'd20, 32'd22, 1'b0, 1'b0, 2'b10, 1'b0, '{32'd42, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ra  = rand_val();
      rb  = rand_val();
      rai = 1'($urandom_range(0, 1));
      rbi = 1'($urandom_range(0, 1));
      rop = 2'($urandom_range(0, 3));
      rm  = ($urandom_range(0, 9) == 0);
      send(ra, rb, rai, rbi, rop, rm, model(ra, rb, rai, rbi, rop, rm));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
